// File: rtl/mips16_mem_pkg.sv
// Shared definitions for the MIPS-16b data-memory path: FSM states, sizes and word extension.
package mips16_mem_pkg;

  localparam int unsigned MEM_DEPTH  = 256;
  localparam int          MEM_WORD_W = 16;
  localparam int          BUS_W      = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  // Only the low memory word is meaningful; upper bus bits are replaced by the extension.
  function automatic logic [BUS_W-1:0] extend_word(input logic [BUS_W-1:0] data, input logic sgn);
    return {{(BUS_W-MEM_WORD_W){sgn & data[MEM_WORD_W-1]}}, data[MEM_WORD_W-1:0]};
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Data-memory initiator: one request at a time, strobes held WAIT_CYCLES+1 cycles, response WAIT_CYCLES+1 cycles after accept.
// Out-of-range requests answer after one cycle with no strobe; a stalled response blocks new requests until it is taken.
module mem_access_unit
  import mips16_mem_pkg::*;
#(
  parameter int unsigned DEPTH       = MEM_DEPTH,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic             req_signed,
  input  logic [BUS_W-1:0] req_addr,
  input  logic [BUS_W-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [BUS_W-1:0] resp_rdata,
  output logic             resp_err,
  output logic [BUS_W-1:0] rw_addr,
  output logic [BUS_W-1:0] w_data,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [BUS_W-1:0] r_data
);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic             r_we, r_signed;
  logic [BUS_W-1:0] r_addr, r_wdata, r_rdata;
  logic             r_err, r_resp_vld, r_rd, r_wr;
  logic             w_rd_nxt, w_wr_nxt, w_resp_vld_nxt;
  logic             w_accept, w_in_range, w_done, w_we_eff;

  assign w_accept   = (r_state == IDLE) && req_valid;
  assign w_in_range = req_addr < BUS_W'(DEPTH);
  assign w_done     = (r_state == ACCESS) && (r_cnt == 4'd0);
  assign w_we_eff   = w_accept ? req_we : r_we;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_in_range) begin
            w_state_nxt = ACCESS;
            w_cnt_nxt   = 4'(WAIT_CYCLES);
          end else begin
            w_state_nxt = RESP;
          end
        end
      end
      ACCESS: begin
        if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
        else               w_state_nxt = RESP;
      end
      RESP: begin
        if (resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Strobes and resp_valid are registered copies of the next state.
    w_rd_nxt       = (w_state_nxt == ACCESS) && !w_we_eff;
    w_wr_nxt       = (w_state_nxt == ACCESS) &&  w_we_eff;
    w_resp_vld_nxt = (w_state_nxt == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_resp_vld <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rd       <= w_rd_nxt;
      r_wr       <= w_wr_nxt;
      r_resp_vld <= w_resp_vld_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we;
        r_signed <= req_signed;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        if (!w_in_range) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end
      end
      if (w_done) begin
        r_rdata <= r_we ? '0 : extend_word(r_data, r_signed);
        r_err   <= 1'b0;
      end
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = r_resp_vld;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign rw_addr    = r_addr;
  assign w_data     = r_wdata;
  assign mem_read   = r_rd;
  assign mem_write  = r_wr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: three instances (WAIT_CYCLES 1, 4, 0), each with its own word memory and reference model.
module tb_mem_access_unit;
  import mips16_mem_pkg::*;

  localparam int NI = 3;
  localparam int MD = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [NI];
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic        req_we     [NI];
  logic        req_signed [NI];
  logic [31:0] req_addr   [NI];
  logic [31:0] req_wdata  [NI];
  logic        resp_valid [NI];
  logic        resp_ready [NI];
  logic [31:0] resp_rdata [NI];
  logic        resp_err   [NI];
  logic [31:0] rw_addr    [NI];
  logic [31:0] w_data     [NI];
  logic        mem_read   [NI];
  logic        mem_write  [NI];
  logic [31:0] r_data     [NI];

  logic [15:0] dmem      [NI][MD];
  logic [15:0] model_mem [NI][MD];
  logic        mem_init;

  int checks = 0;
  int errors = 0;

  function automatic int wc(int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 0);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_access_unit #(
      .DEPTH      (MD),
      .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 4 : 0))
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_signed(req_signed[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g]),
      .rw_addr   (rw_addr[g]),
      .w_data    (w_data[g]),
      .mem_read  (mem_read[g]),
      .mem_write (mem_write[g]),
      .r_data    (r_data[g])
    );
    // Upper read-data bits carry junk that the unit must ignore.
    assign r_data[g] = (rw_addr[g] < MD) ? {16'hA5A5, dmem[g][rw_addr[g][7:0]]} : 32'hA5A5_5A5A;
  end

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (mem_init) begin
        for (int i = 0; i < MD; i++) dmem[k][i] <= 16'(i);
      end else if (mem_write[k] && rw_addr[k] < MD) begin
        dmem[k][rw_addr[k][7:0]] <= w_data[k][15:0];
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference behaviour: range check, word store, zero/sign extension by arithmetic.
  task automatic model_req(int k, logic we, logic sgn, logic [31:0] addr, logic [31:0] wd,
                           output logic [31:0] rd, output logic err);
    int unsigned word;
    if (addr >= MD) begin
      rd = 32'd0; err = 1'b1;
    end else if (we) begin
      model_mem[k][addr[7:0]] = wd[15:0];
      rd = 32'd0; err = 1'b0;
    end else begin
      word = int'(model_mem[k][addr[7:0]]);
      rd   = (sgn && word >= 32768) ? word + 32'hFFFF_0000 : word;
      err  = 1'b0;
    end
  endtask

  // Called at a negedge; returns at a negedge with the unit back in IDLE.
  task automatic do_req(int k, logic we, logic sgn, logic [31:0] addr, logic [31:0] wd, int hold,
                        output logic [31:0] rd, output logic err,
                        output int lat, output int nstb, output int bad);
    int t;
    lat = 0; nstb = 0; bad = 0; rd = '0; err = 1'b0; t = 0;
    while (!req_ready[k] && t < 50) begin @(negedge clk); t++; end
    if (!req_ready[k]) bad++;
    req_valid[k] = 1'b1; req_we[k] = we; req_signed[k] = sgn;
    req_addr[k] = addr;  req_wdata[k] = wd; resp_ready[k] = 1'b0;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_read[k] && mem_write[k]) bad++;
      if (mem_read[k] || mem_write[k]) begin
        nstb++;
        if (rw_addr[k] !== addr) bad++;
        if (mem_write[k] !== we) bad++;
        if (we && w_data[k] !== wd) bad++;
      end
      if (resp_valid[k]) begin lat = c; break; end
    end
    rd  = resp_rdata[k];
    err = resp_err[k];
    for (int h = 0; h < hold; h++) begin
      req_valid[k] = 1'b1; req_we[k] = 1'b1; req_addr[k] = 32'(h); req_wdata[k] = $urandom;
      @(negedge clk);
      if (resp_valid[k] !== 1'b1 || resp_rdata[k] !== rd || resp_err[k] !== err) bad++;
      if (req_ready[k] !== 1'b0 || mem_read[k] || mem_write[k]) bad++;
    end
    req_valid[k] = 1'b0; resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    resp_ready[k] = 1'b0;
    @(negedge clk);
    if (resp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1) bad++;
  endtask

  task automatic chk_timing(string tag, int k, logic [31:0] addr, int lat, int nstb, int bad);
    chk({tag, "_lat"}, 32'(lat), (addr < MD) ? 32'(wc(k) + 2) : 32'd1);
    chk({tag, "_stb"}, 32'(nstb), (addr < MD) ? 32'(wc(k) + 1) : 32'd0);
    chk({tag, "_bus"}, 32'(bad), 32'd0);
  endtask

  task automatic spacing_test(int k, int n_acc);
    int acc_cyc[$];
    logic [31:0] exp_q[$];
    logic [31:0] rd;
    logic e, took;
    int cyc, nstb;
    cyc = 0; nstb = 0;
    resp_ready[k] = 1'b1; req_we[k] = 1'b0; req_signed[k] = 1'($urandom);
    req_addr[k] = $urandom_range(0, MD - 1); req_valid[k] = 1'b1;
    while (acc_cyc.size() < n_acc && cyc < 200) begin
      if (mem_read[k] || mem_write[k]) nstb++;
      if (resp_valid[k]) begin
        if (exp_q.size() > 0) chk("b2b_rdata", resp_rdata[k], exp_q.pop_front());
        else chk("b2b_extra_resp", 32'd1, 32'd0);
      end
      took = req_ready[k];
      if (took) begin
        acc_cyc.push_back(cyc);
        model_req(k, 1'b0, req_signed[k], req_addr[k], 32'd0, rd, e);
        exp_q.push_back(rd);
      end
      @(posedge clk); #1;
      if (took) begin
        req_addr[k] = $urandom_range(0, MD - 1); req_signed[k] = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    req_valid[k] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (mem_read[k] || mem_write[k]) nstb++;
      if (resp_valid[k] && exp_q.size() > 0) chk("b2b_rdata", resp_rdata[k], exp_q.pop_front());
      @(negedge clk);
    end
    resp_ready[k] = 1'b0;
    chk("b2b_count", 32'(acc_cyc.size()), 32'(n_acc));
    chk("b2b_pending", 32'(exp_q.size()), 32'd0);
    chk("b2b_strobe_cycles", 32'(nstb), 32'(n_acc * (wc(k) + 1)));
    for (int i = 1; i < acc_cyc.size(); i++)
      chk($sformatf("b2b_spacing_i%0d_%0d", k, i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(wc(k) + 3));
  endtask

  typedef struct {
    int          k;
    logic        we;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wd;
    int          hold;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[10];
    logic [31:0] rd, mrd;
    logic        err, merr, we, sgn;
    logic [31:0] addr, wd;
    int          lat, nstb, bad, hold, cnt;

    tbl[0] = '{0, 1'b0, 1'b0, 32'd5,          32'd0,          0, 32'h0000_0005, 1'b0};
    tbl[1] = '{0, 1'b1, 1'b0, 32'd10,         32'h1234_ABCD,  0, 32'h0000_0000, 1'b0};
    tbl[2] = '{0, 1'b0, 1'b1, 32'd10,         32'd0,          0, 32'hFFFF_ABCD, 1'b0};
    tbl[3] = '{0, 1'b0, 1'b0, 32'd10,         32'd0,          0, 32'h0000_ABCD, 1'b0};
    tbl[4] = '{0, 1'b0, 1'b0, 32'd256,        32'd0,          0, 32'h0000_0000, 1'b1};
    tbl[5] = '{0, 1'b1, 1'b0, 32'hFFFF_FFFF,  32'h0000_5555,  0, 32'h0000_0000, 1'b1};
    tbl[6] = '{0, 1'b0, 1'b1, 32'd200,        32'd0,          5, 32'h0000_00C8, 1'b0};
    tbl[7] = '{1, 1'b0, 1'b1, 32'd255,        32'd0,          0, 32'h0000_00FF, 1'b0};
    tbl[8] = '{2, 1'b1, 1'b0, 32'd3,          32'h0000_8001,  0, 32'h0000_0000, 1'b0};
    tbl[9] = '{2, 1'b0, 1'b1, 32'd3,          32'd0,          0, 32'hFFFF_8001, 1'b0};

    mem_init = 1'b1;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_signed[k] = 1'b0;
      req_addr[k] = 32'd0; req_wdata[k] = 32'd0; resp_ready[k] = 1'b0;
      for (int i = 0; i < MD; i++) model_mem[k][i] = 16'(i);
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b0;
    end
    mem_init = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_req_ready_%0d", k),  32'(req_ready[k]),  32'd1);
      chk($sformatf("rst_resp_valid_%0d", k), 32'(resp_valid[k]), 32'd0);
      chk($sformatf("rst_rdata_%0d", k),      resp_rdata[k],      32'd0);
      chk($sformatf("rst_err_%0d", k),        32'(resp_err[k]),   32'd0);
      chk($sformatf("rst_strobes_%0d", k),    {30'd0, mem_read[k], mem_write[k]}, 32'd0);
      chk($sformatf("rst_rw_addr_%0d", k),    rw_addr[k],         32'd0);
      chk($sformatf("rst_w_data_%0d", k),     w_data[k],          32'd0);
    end

    for (int i = 0; i < 10; i++) begin
      do_req(tbl[i].k, tbl[i].we, tbl[i].sgn, tbl[i].addr, tbl[i].wd, tbl[i].hold, rd, err, lat, nstb, bad);
      model_req(tbl[i].k, tbl[i].we, tbl[i].sgn, tbl[i].addr, tbl[i].wd, mrd, merr);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
      chk_timing($sformatf("vec%0d", i), tbl[i].k, tbl[i].addr, lat, nstb, bad);
    end

    // Reset while a WAIT_CYCLES=4 store is two cycles into its strobe window.
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_signed[1] = 1'b0;
    req_addr[1] = 32'd20; req_wdata[1] = 32'h0000_BEEF;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_pre_write", 32'(mem_write[1]), 32'd1);
    #2 rst[1] = 1'b1;
    #1;
    chk("rst_mid_write_drop", 32'(mem_write[1]), 32'd0);
    chk("rst_mid_read_drop", 32'(mem_read[1]), 32'd0);
    @(negedge clk);
    rst[1] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1 || mem_read[1] || mem_write[1]) cnt++;
    end
    chk("rst_mid_idle_after", 32'(cnt), 32'd0);
    // The interrupted store may or may not have landed.
    model_mem[1][20] = dmem[1][20];
    do_req(1, 1'b0, 1'b0, 32'd5, 32'd0, 0, rd, err, lat, nstb, bad);
    chk("rst_mid_followup_rdata", rd, 32'd5);
    chk_timing("rst_mid_followup", 1, 32'd5, lat, nstb, bad);

    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 25; n++) begin
        we   = 1'($urandom);
        sgn  = 1'($urandom);
        wd   = $urandom;
        hold = $urandom_range(0, 2);
        case ($urandom_range(0, 9))
          0:       addr = 32'hFFFF_FFFF;
          1:       addr = 32'(MD) + $urandom_range(0, 4000);
          default: addr = $urandom_range(0, MD - 1);
        endcase
        do_req(k, we, sgn, addr, wd, hold, rd, err, lat, nstb, bad);
        model_req(k, we, sgn, addr, wd, mrd, merr);
        chk($sformatf("rnd%0d_%0d_rdata", k, n), rd, mrd);
        chk($sformatf("rnd%0d_%0d_err", k, n), 32'(err), 32'(merr));
        chk_timing($sformatf("rnd%0d_%0d", k, n), k, addr, lat, nstb, bad);
      end
    end

    spacing_test(2, 6);
    spacing_test(0, 4);

    for (int k = 0; k < NI; k++) begin
      cnt = 0;
      for (int i = 0; i < MD; i++) if (dmem[k][i] !== model_mem[k][i]) cnt++;
      chk($sformatf("mem_contents_%0d", k), 32'(cnt), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
